// File: rtl/forward_hazard_unit.sv
// Forwarding-select, load-use stall and flush-squash control for a 5-stage pipeline.
// Define HAZARD_PERF_CNT_EN to add saturating stall/flush event counters.
package forward_hazard_pkg;
    typedef enum logic [1:0] {
        NO_FORWARD_SELECT = 2'b00,
        EX_RESULT_SELECT  = 2'b01,
        WB_RESULT_SELECT  = 2'b10
    } forward_mux_code;
endpackage

module forward_hazard_unit
    import forward_hazard_pkg::*;
#(
    parameter int unsigned FLUSH_DEPTH = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            id_valid_ip,
    input  logic [4:0]      id_rs1_addr_ip,
    input  logic [4:0]      id_rs2_addr_ip,
    input  logic            id_rs1_used_ip,
    input  logic            id_rs2_used_ip,
    input  logic [4:0]      id_write_reg_addr_ip,
    input  logic            id_reg_write_ip,
    input  logic            id_is_load_ip,
    input  logic            flush_en_ip,
    output forward_mux_code fa_mux_op,
    output forward_mux_code fb_mux_op,
    output logic            stall_op,
    output logic            squash_op
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]     stall_count_op,
    output logic [31:0]     flush_count_op
`endif
);

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_DEPTH - 1);

    logic [4:0]      ex_dst_r;
    logic            ex_wr_r;
    logic            ex_load_r;
    logic [4:0]      mem_dst_r;
    logic            mem_wr_r;
    logic [2:0]      flush_cnt_r;
    logic            src_hit_s;
    logic            stall_s;
    logic            squash_s;
    logic            accept_s;
    forward_mux_code fa_next_s;
    forward_mux_code fb_next_s;

    // Youngest in-flight writer wins; x0 and unread sources never forward.
    function automatic forward_mux_code fwd_sel(
        input logic [4:0] src,
        input logic       used,
        input logic       ex_wr,
        input logic [4:0] ex_dst,
        input logic       mem_wr,
        input logic [4:0] mem_dst
    );
        forward_mux_code sel;
        sel = NO_FORWARD_SELECT;
        if (used && (src != 5'd0)) begin
            if (ex_wr && (ex_dst == src)) begin
                sel = EX_RESULT_SELECT;
            end else if (mem_wr && (mem_dst == src)) begin
                sel = WB_RESULT_SELECT;
            end else begin
                sel = NO_FORWARD_SELECT;
            end
        end else begin
            sel = NO_FORWARD_SELECT;
        end
        return sel;
    endfunction

    // Hazard detection and next forwarding selects for the decode instruction.
    always_comb begin
        src_hit_s = (id_rs1_used_ip && (id_rs1_addr_ip == ex_dst_r)) ||
                    (id_rs2_used_ip && (id_rs2_addr_ip == ex_dst_r));
        squash_s  = reset && (flush_en_ip || (flush_cnt_r != 3'd0));
        stall_s   = reset && id_valid_ip && ex_load_r && ex_wr_r &&
                    (ex_dst_r != 5'd0) && src_hit_s && !squash_s;
        accept_s  = id_valid_ip && !stall_s && !squash_s;
        fa_next_s = NO_FORWARD_SELECT;
        fb_next_s = NO_FORWARD_SELECT;
        if (accept_s) begin
            fa_next_s = fwd_sel(id_rs1_addr_ip, id_rs1_used_ip, ex_wr_r, ex_dst_r, mem_wr_r, mem_dst_r);
            fb_next_s = fwd_sel(id_rs2_addr_ip, id_rs2_used_ip, ex_wr_r, ex_dst_r, mem_wr_r, mem_dst_r);
        end else begin
            fa_next_s = NO_FORWARD_SELECT;
            fb_next_s = NO_FORWARD_SELECT;
        end
    end

    assign stall_op  = stall_s;
    assign squash_op = squash_s;

    // In-flight EX/MEM tracking, registered selects and flush down-counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_dst_r    <= 5'd0;
            ex_wr_r     <= 1'b0;
            ex_load_r   <= 1'b0;
            mem_dst_r   <= 5'd0;
            mem_wr_r    <= 1'b0;
            flush_cnt_r <= 3'd0;
            fa_mux_op   <= NO_FORWARD_SELECT;
            fb_mux_op   <= NO_FORWARD_SELECT;
        end else begin
            mem_dst_r <= ex_dst_r;
            mem_wr_r  <= ex_wr_r;
            if (accept_s) begin
                ex_dst_r  <= id_write_reg_addr_ip;
                ex_wr_r   <= id_reg_write_ip;
                ex_load_r <= id_is_load_ip;
            end else begin
                ex_dst_r  <= 5'd0;
                ex_wr_r   <= 1'b0;
                ex_load_r <= 1'b0;
            end
            if (flush_en_ip) begin
                flush_cnt_r <= FLUSH_RELOAD;
            end else if (flush_cnt_r != 3'd0) begin
                flush_cnt_r <= flush_cnt_r - 3'd1;
            end else begin
                flush_cnt_r <= 3'd0;
            end
            fa_mux_op <= fa_next_s;
            fb_mux_op <= fb_next_s;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic flush_prev_r;

    // Saturating event counters; a held flush counts once on its first cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flush_prev_r   <= 1'b0;
            stall_count_op <= 32'd0;
            flush_count_op <= 32'd0;
        end else begin
            flush_prev_r <= flush_en_ip;
            if (stall_s && (stall_count_op != 32'hFFFF_FFFF)) begin
                stall_count_op <= stall_count_op + 32'd1;
            end else begin
                stall_count_op <= stall_count_op;
            end
            if (flush_en_ip && !flush_prev_r && (flush_count_op != 32'hFFFF_FFFF)) begin
                flush_count_op <= flush_count_op + 32'd1;
            end else begin
                flush_count_op <= flush_count_op;
            end
        end
    end
`endif

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Self-checking bench for forward_hazard_unit: directed pipeline scenarios plus
// randomized traffic compared against an in-flight-instruction queue model.
module tb_forward_hazard_unit;
    import forward_hazard_pkg::*;

    localparam int FLUSH_DEPTH = 2;

    logic            clock;
    logic            reset;
    logic            id_valid_ip;
    logic [4:0]      id_rs1_addr_ip;
    logic [4:0]      id_rs2_addr_ip;
    logic            id_rs1_used_ip;
    logic            id_rs2_used_ip;
    logic [4:0]      id_write_reg_addr_ip;
    logic            id_reg_write_ip;
    logic            id_is_load_ip;
    logic            flush_en_ip;
    forward_mux_code fa_mux_op;
    forward_mux_code fb_mux_op;
    logic            stall_op;
    logic            squash_op;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]     stall_count_op;
    logic [31:0]     flush_count_op;
`endif

    int checks = 0;
    int errors = 0;

    forward_hazard_unit #(.FLUSH_DEPTH(FLUSH_DEPTH)) dut (
        .clock                (clock),
        .reset                (reset),
        .id_valid_ip          (id_valid_ip),
        .id_rs1_addr_ip       (id_rs1_addr_ip),
        .id_rs2_addr_ip       (id_rs2_addr_ip),
        .id_rs1_used_ip       (id_rs1_used_ip),
        .id_rs2_used_ip       (id_rs2_used_ip),
        .id_write_reg_addr_ip (id_write_reg_addr_ip),
        .id_reg_write_ip      (id_reg_write_ip),
        .id_is_load_ip        (id_is_load_ip),
        .flush_en_ip          (flush_en_ip),
        .fa_mux_op            (fa_mux_op),
        .fb_mux_op            (fb_mux_op),
        .stall_op             (stall_op),
        .squash_op            (squash_op)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_count_op       (stall_count_op),
        .flush_count_op       (flush_count_op)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: queue of instructions in flight, index 0 = in execute.
    typedef struct {
        logic       wr;
        logic       load;
        logic [4:0] dst;
    } slot_t;

    slot_t           inflight[$];
    forward_mux_code exp_fa;
    forward_mux_code exp_fb;
    logic            exp_stall;
    logic            exp_squash;
    int              cyc;
    int              kill_until;
    int              m_stall_cnt;
    int              m_flush_cnt;
    logic            prev_flush;

    function automatic forward_mux_code model_fwd(input logic [4:0] src, input logic used);
        if (!used || src == 5'd0) return NO_FORWARD_SELECT;
        for (int k = 0; k < 2; k++) begin
            if (inflight[k].wr && inflight[k].dst == src)
                return (k == 0) ? EX_RESULT_SELECT : WB_RESULT_SELECT;
        end
        return NO_FORWARD_SELECT;
    endfunction

    task automatic model_reset();
        slot_t b;
        b.wr = 1'b0; b.load = 1'b0; b.dst = 5'd0;
        inflight.delete();
        inflight.push_back(b);
        inflight.push_back(b);
        exp_fa = NO_FORWARD_SELECT;
        exp_fb = NO_FORWARD_SELECT;
        cyc = 0;
        kill_until = -100;
        m_stall_cnt = 0;
        m_flush_cnt = 0;
        prev_flush = 1'b0;
    endtask

    task automatic model_eval();
        logic hit;
        hit = (id_rs1_used_ip && id_rs1_addr_ip == inflight[0].dst) ||
              (id_rs2_used_ip && id_rs2_addr_ip == inflight[0].dst);
        exp_squash = flush_en_ip || (cyc <= kill_until);
        exp_stall  = id_valid_ip && inflight[0].load && inflight[0].wr &&
                     (inflight[0].dst != 5'd0) && hit && !exp_squash;
    endtask

    task automatic drive(input logic v, input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2, input logic [4:0] wd,
                         input logic wr, input logic ld, input logic fl);
        id_valid_ip = v; id_rs1_addr_ip = r1; id_rs1_used_ip = u1;
        id_rs2_addr_ip = r2; id_rs2_used_ip = u2; id_write_reg_addr_ip = wd;
        id_reg_write_ip = wr; id_is_load_ip = ld; flush_en_ip = fl;
    endtask

    task automatic settle();
        @(negedge clock);
        model_eval();
    endtask

    task automatic advance();
        slot_t s;
        forward_mux_code nfa, nfb;
        if (id_valid_ip && !exp_stall && !exp_squash) begin
            nfa = model_fwd(id_rs1_addr_ip, id_rs1_used_ip);
            nfb = model_fwd(id_rs2_addr_ip, id_rs2_used_ip);
            s.wr = id_reg_write_ip; s.load = id_is_load_ip; s.dst = id_write_reg_addr_ip;
        end else begin
            nfa = NO_FORWARD_SELECT;
            nfb = NO_FORWARD_SELECT;
            s.wr = 1'b0; s.load = 1'b0; s.dst = 5'd0;
        end
        if (flush_en_ip) kill_until = cyc + FLUSH_DEPTH - 1;
        if (exp_stall) m_stall_cnt++;
        if (flush_en_ip && !prev_flush) m_flush_cnt++;
        prev_flush = flush_en_ip;
        inflight.push_front(s);
        void'(inflight.pop_back());
        @(posedge clock);
        #1;
        cyc++;
        exp_fa = nfa;
        exp_fb = nfb;
    endtask

    task automatic apply_reset();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        model_reset();
    endtask

    task automatic test_reset();
        drive(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 1'b1);
        @(negedge clock);
        checks++; if (stall_op !== 1'b0) begin errors++; $display("FAIL rst_stall: got %0b expected 0", stall_op); end
        checks++; if (squash_op !== 1'b0) begin errors++; $display("FAIL rst_squash: got %0b expected 0", squash_op); end
        checks++; if (fa_mux_op !== NO_FORWARD_SELECT) begin errors++; $display("FAIL rst_fa: got %0d expected %0d", fa_mux_op, NO_FORWARD_SELECT); end
        checks++; if (fb_mux_op !== NO_FORWARD_SELECT) begin errors++; $display("FAIL rst_fb: got %0d expected %0d", fb_mux_op, NO_FORWARD_SELECT); end
`ifdef HAZARD_PERF_CNT_EN
        checks++; if (stall_count_op !== 32'd0 || flush_count_op !== 32'd0) begin errors++; $display("FAIL rst_counts: got %0d/%0d expected 0/0", stall_count_op, flush_count_op); end
`endif
        apply_reset();
    endtask

    task automatic test_ex_forward();
        apply_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0); settle(); advance();
        drive(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0); settle();
        checks++; if (stall_op !== 1'b0) begin errors++; $display("FAIL exfwd_stall: got %0b expected 0", stall_op); end
        advance();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); settle();
        checks++; if (fa_mux_op !== EX_RESULT_SELECT) begin errors++; $display("FAIL exfwd_fa: got %0d expected %0d", fa_mux_op, EX_RESULT_SELECT); end
        checks++; if (fb_mux_op !== NO_FORWARD_SELECT) begin errors++; $display("FAIL exfwd_fb: got %0d expected %0d", fb_mux_op, NO_FORWARD_SELECT); end
        advance();
    endtask

    task automatic test_wb_forward();
        apply_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0); settle(); advance();
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0); settle(); advance();
        drive(1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0); settle(); advance();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); settle();
        checks++; if (fb_mux_op !== WB_RESULT_SELECT) begin errors++; $display("FAIL wbfwd_fb: got %0d expected %0d", fb_mux_op, WB_RESULT_SELECT); end
        checks++; if (fa_mux_op !== NO_FORWARD_SELECT) begin errors++; $display("FAIL wbfwd_fa: got %0d expected %0d", fa_mux_op, NO_FORWARD_SELECT); end
        advance();
    endtask

    task automatic test_load_use();
        apply_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0); settle(); advance();
        drive(1'b1, 5'd7, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0); settle();
        checks++; if (stall_op !== 1'b1) begin errors++; $display("FAIL lu_stall1: got %0b expected 1", stall_op); end
        advance(); settle();
        checks++; if (stall_op !== 1'b0) begin errors++; $display("FAIL lu_stall2: got %0b expected 0", stall_op); end
        checks++; if (fa_mux_op !== NO_FORWARD_SELECT) begin errors++; $display("FAIL lu_bubble_fa: got %0d expected %0d", fa_mux_op, NO_FORWARD_SELECT); end
        advance();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); settle();
        checks++; if (fa_mux_op !== WB_RESULT_SELECT) begin errors++; $display("FAIL lu_fa: got %0d expected %0d", fa_mux_op, WB_RESULT_SELECT); end
        checks++; if (fb_mux_op !== NO_FORWARD_SELECT) begin errors++; $display("FAIL lu_fb: got %0d expected %0d", fb_mux_op, NO_FORWARD_SELECT); end
        advance();
    endtask

    task automatic test_x0();
        apply_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0); settle(); advance();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0); settle();
        checks++; if (stall_op !== 1'b0) begin errors++; $display("FAIL x0_stall_a: got %0b expected 0", stall_op); end
        advance();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0); settle();
        checks++; if (fa_mux_op !== NO_FORWARD_SELECT || fb_mux_op !== NO_FORWARD_SELECT) begin errors++; $display("FAIL x0_fwd_a: got %0d/%0d expected 0/0", fa_mux_op, fb_mux_op); end
        advance();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0); settle();
        checks++; if (stall_op !== 1'b0) begin errors++; $display("FAIL x0_stall_lw: got %0b expected 0", stall_op); end
        advance();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); settle();
        checks++; if (fa_mux_op !== NO_FORWARD_SELECT || fb_mux_op !== NO_FORWARD_SELECT) begin errors++; $display("FAIL x0_fwd_lw: got %0d/%0d expected 0/0", fa_mux_op, fb_mux_op); end
        advance();
    endtask

    task automatic test_flush();
        apply_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0); settle(); advance();
        drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1); settle();
        checks++; if (squash_op !== 1'b1 || stall_op !== 1'b0) begin errors++; $display("FAIL fl_c1: got squash=%0b stall=%0b expected 1/0", squash_op, stall_op); end
        advance();
        drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0); settle();
        checks++; if (squash_op !== 1'b1 || stall_op !== 1'b0) begin errors++; $display("FAIL fl_c2: got squash=%0b stall=%0b expected 1/0", squash_op, stall_op); end
        advance();
        drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0); settle();
        checks++; if (squash_op !== 1'b0) begin errors++; $display("FAIL fl_c3: got %0b expected 0", squash_op); end
        advance();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); settle();
        checks++; if (fa_mux_op !== NO_FORWARD_SELECT) begin errors++; $display("FAIL fl_fa: got %0d expected %0d", fa_mux_op, NO_FORWARD_SELECT); end
        advance();
    endtask

    task automatic test_reset_abort();
        apply_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0); settle(); advance();
        drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0); settle();
        checks++; if (stall_op !== 1'b1) begin errors++; $display("FAIL ab_pre_stall: got %0b expected 1", stall_op); end
        reset = 1'b0; #1;
        checks++; if (stall_op !== 1'b0) begin errors++; $display("FAIL ab_stall: got %0b expected 0", stall_op); end
        apply_reset();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1); settle(); advance();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); settle();
        checks++; if (squash_op !== 1'b1) begin errors++; $display("FAIL ab_pre_squash: got %0b expected 1", squash_op); end
        reset = 1'b0; #1;
        checks++; if (squash_op !== 1'b0) begin errors++; $display("FAIL ab_squash: got %0b expected 0", squash_op); end
        apply_reset();
        drive(1'b1, 5'd7, 1'b1, 5'd4, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0); settle();
        checks++; if (squash_op !== 1'b0 || stall_op !== 1'b0) begin errors++; $display("FAIL ab_post: got squash=%0b stall=%0b expected 0/0", squash_op, stall_op); end
        advance();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); settle();
        checks++; if (fa_mux_op !== NO_FORWARD_SELECT || fb_mux_op !== NO_FORWARD_SELECT) begin errors++; $display("FAIL ab_post_fwd: got %0d/%0d expected 0/0", fa_mux_op, fb_mux_op); end
        advance();
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf_counts();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0); settle(); advance();
            drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0); settle(); advance();
            settle(); advance();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1); settle(); advance();
            drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); settle(); advance();
        end
        settle();
        checks++; if (stall_count_op !== 32'd3) begin errors++; $display("FAIL perf_stall: got %0d expected 3", stall_count_op); end
        checks++; if (flush_count_op !== 32'd2) begin errors++; $display("FAIL perf_flush: got %0d expected 2", flush_count_op); end
        reset = 1'b0; #1;
        checks++; if (stall_count_op !== 32'd0 || flush_count_op !== 32'd0) begin errors++; $display("FAIL perf_rst: got %0d/%0d expected 0/0", stall_count_op, flush_count_op); end
        apply_reset();
    endtask
`endif

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 500; i++) begin
            drive(1'($urandom_range(0, 7) != 0),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0));
            settle();
            checks++; if (stall_op !== exp_stall) begin errors++; $display("FAIL rnd_stall cyc %0d: got %0b expected %0b", cyc, stall_op, exp_stall); end
            checks++; if (squash_op !== exp_squash) begin errors++; $display("FAIL rnd_squash cyc %0d: got %0b expected %0b", cyc, squash_op, exp_squash); end
            checks++; if (fa_mux_op !== exp_fa) begin errors++; $display("FAIL rnd_fa cyc %0d: got %0d expected %0d", cyc, fa_mux_op, exp_fa); end
            checks++; if (fb_mux_op !== exp_fb) begin errors++; $display("FAIL rnd_fb cyc %0d: got %0d expected %0d", cyc, fb_mux_op, exp_fb); end
`ifdef HAZARD_PERF_CNT_EN
            checks++; if (stall_count_op !== 32'(m_stall_cnt) || flush_count_op !== 32'(m_flush_cnt)) begin errors++; $display("FAIL rnd_counts cyc %0d: got %0d/%0d expected %0d/%0d", cyc, stall_count_op, flush_count_op, m_stall_cnt, m_flush_cnt); end
`endif
            advance();
        end
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        model_reset();
        test_reset();
        test_ex_forward();
        test_wb_forward();
        test_load_use();
        test_x0();
        test_flush();
        test_reset_abort();
`ifdef HAZARD_PERF_CNT_EN
        test_perf_counts();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/forward_hazard_unit.md
FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 SHALL have parameter FLUSH_DEPTH, default 2, the number of consecutive decode-stage instructions squashed per flush (legal 1..7).
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates occur on the rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port id_valid_ip, input, 1, decode-stage instruction valid.
REQ-005 SHALL have ports id_rs1_addr_ip / id_rs2_addr_ip, input, 5 each, decode source register addresses.
REQ-006 SHALL have ports id_rs1_used_ip / id_rs2_used_ip, input, 1 each, source actually read by the instruction.
REQ-007 SHALL have port id_write_reg_addr_ip, input, 5, decode destination register.
REQ-008 SHALL have port id_reg_write_ip, input, 1, decode instruction writes a register.
REQ-009 SHALL have port id_is_load_ip, input, 1, decode instruction is a load.
REQ-010 SHALL have port flush_en_ip, input, 1, taken-jump/branch flush from the execute stage (same cycle).
REQ-011 SHALL have ports fa_mux_op / fb_mux_op, output, forward_mux_code, registered operand-A/B select consumed by execute.
REQ-012 SHALL have port stall_op, output, 1, hold PC and IF/ID register, insert an execute bubble.
REQ-013 SHALL have port squash_op, output, 1, the current decode instruction is killed.
REQ-014 SHALL have ports stall_count_op / flush_count_op, output, 32 each, present only under HAZARD_PERF_CNT_EN.

Function
REQ-015 SHALL track two in-flight entries: EX {dst, wr, load} for the instruction entering execute, and MEM {dst, wr} for the one entering memory.
REQ-016 Each edge SHALL shift MEM <= EX; EX <= decode fields when id_valid_ip=1 and stall_op=0 and squash_op=0, else a bubble (wr=0, load=0).
REQ-017 Next fa_mux_op SHALL be EX_RESULT_SELECT if rs1 used, rs1!=0, EX.wr and EX.dst==rs1; else WB_RESULT_SELECT if MEM.wr and MEM.dst==rs1; else NO_FORWARD_SELECT (non-forwarding member of forward_mux_code).
REQ-018 fb_mux_op SHALL follow REQ-017 using rs2; EX match SHALL take priority over MEM match.
REQ-019 When the decode slot becomes a bubble (invalid, stall or squash), the next fa/fb SHALL be NO_FORWARD_SELECT.
REQ-020 stall_op SHALL be combinational: id_valid_ip and EX.load and EX.wr and EX.dst!=0 and a used source matches EX.dst, and squash_op=0.
REQ-021 A load-use stall SHALL last exactly one cycle; after it the consumer SHALL receive WB_RESULT_SELECT for the load operand.
REQ-022 On flush_en_ip=1 a down-counter SHALL load FLUSH_DEPTH-1; squash_op = flush_en_ip OR counter!=0; counter decrements to 0 and does not wrap.
REQ-023 flush_en_ip during a nonzero count SHALL reload the counter to FLUSH_DEPTH-1.
REQ-024 Simultaneous flush and load-use SHALL give squash_op=1, stall_op=0.
REQ-025 Register x0 SHALL never produce forwarding or stall.
REQ-026 Writes by an instruction already past WB SHALL NOT be tracked; the register file provides write-before-read.

Reset
REQ-027 While reset=0: EX/MEM entries bubble with dst=0, counter 0, fa/fb NO_FORWARD_SELECT, stall_op=0, squash_op=0 regardless of inputs, counts 0.
REQ-028 Reset asserted mid-stall or mid-flush SHALL abort it immediately; first post-reset decode instruction sees no forwarding.

Configuration
REQ-029 With HAZARD_PERF_CNT_EN defined: stall_count_op increments once per cycle stall_op=1, flush_count_op once per flush_en_ip rising cycle; both saturate at 0xFFFFFFFF.
REQ-030 Without HAZARD_PERF_CNT_EN: count ports and counters SHALL be absent; all other behaviour is identical.

Verification
REQ-031 add x5 then add rs1=x5 next cycle -> consumer execute cycle fa=EX_RESULT_SELECT, fb=NO_FORWARD_SELECT, no stall.
REQ-032 add x5, unrelated instruction, add rs2=x5 -> fb=WB_RESULT_SELECT, fa=NO_FORWARD_SELECT.
REQ-033 lw x7 then add rs1=x7 -> stall_op=1 for exactly one cycle, then fa=WB_RESULT_SELECT.
REQ-034 writer and reader of x0 back-to-back, also lw x0 -> NO_FORWARD_SELECT, stall_op=0.
REQ-035 flush_en_ip one cycle while a load-use hazard is in decode -> squash_op=1 for 2 cycles, stall_op=0; next valid instruction reading the squashed dst gets NO_FORWARD_SELECT.
REQ-036 With macro: 3 load-use stalls and 2 flushes -> stall_count_op=3, flush_count_op=2; reset low mid-run -> both 0.
